// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Each serial bit is held for CLKS_PER_BIT clocks. x = in_odd selects even (0) / odd (1) parity.
// Optional build macro PARITY_TX_ERR_INJECT_EN: a handshake with inject_err = 1 sends an
// inverted parity bit. Without the macro inject_err is ignored but the port stays present.
module parity_frame_tx #(
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_odd,
  input  logic              inject_err,
  output logic              tx_line,
  output logic              busy,
  output logic              parity_bit,
  output logic              frame_done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e              state_q, state_d;
  logic [BaudW-1:0]    baud_q, baud_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   shifted;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                baud_end;
  logic                inj_bit;

`ifdef PARITY_TX_ERR_INJECT_EN
  assign inj_bit = inject_err;
`else
  // Port kept for a stable port list; its value never reaches the datapath.
  logic unused_inject;
  assign unused_inject = inject_err;
  assign inj_bit       = 1'b0;
`endif

  assign baud_end = (baud_q == BaudLast);
  assign shifted  = shift_q >> 1;

  // Next-state, datapath and registered-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StStart;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = in_data;
          par_d   = (^in_data) ^ in_odd ^ inj_bit;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (baud_end) begin
          state_d = StData;
          baud_d  = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BitLast) begin
            state_d = StParity;
            tx_d    = par_q;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shifted;
            tx_d    = shifted[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StParity: begin
        if (baud_end) begin
          state_d = StStop;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          state_d = StIdle;
          baud_d  = '0;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
    // Registered pulse: high during the cycle that is the last one of the stop bit.
    done_d = (state_d == StStop) && (baud_d == BaudLast);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign tx_line    = tx_q;
  assign busy       = busy_q;
  assign parity_bit = par_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: directed frames plus random frames checked
// cycle by cycle against a frame model built from the bit-level framing rules.
module tb_parity_frame_tx;

  localparam int unsigned DataW = 3;
  localparam int unsigned Cpb   = 4;
  localparam int unsigned FrameLen = (DataW + 3) * Cpb;
`ifdef PARITY_TX_ERR_INJECT_EN
  localparam bit InjEn = 1'b1;
`else
  localparam bit InjEn = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DataW-1:0] in_data;
  logic             in_odd;
  logic             inject_err;
  logic             tx_line;
  logic             busy;
  logic             parity_bit;
  logic             frame_done;

  int checks;
  int failures;
  int cyc;
  int last_hs;
  logic last_par;

  parity_frame_tx #(
    .DATA_W      (DataW),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_odd    (in_odd),
    .inject_err(inject_err),
    .tx_line   (tx_line),
    .busy      (busy),
    .parity_bit(parity_bit),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference parity: count of ones mod 2, flipped for odd mode and for active injection.
  function automatic logic model_parity(input logic [DataW-1:0] d, input logic odd,
                                        input logic inj);
    int ones = 0;
    for (int i = 0; i < DataW; i++) ones += int'(d[i]);
    return logic'((ones % 2) != 0) ^ odd ^ (inj & InjEn);
  endfunction

  // Sends one frame and checks every cycle. Outputs sampled on the falling edge.
  // keep_valid leaves in_valid high; scramble perturbs inputs mid-frame.
  // abort_at > 0 returns after that many frame cycles without finishing.
  task automatic run_frame(input logic [DataW-1:0] d, input logic odd, input logic inj,
                           input bit keep_valid, input int abort_at, input bit chk_gap);
    logic exp_par;
    logic seq[$];
    int   waited;
    int   hs;
    exp_par = model_parity(d, odd, inj);
    seq = {};
    seq.push_back(1'b0);
    for (int i = 0; i < DataW; i++) seq.push_back(d[i]);
    seq.push_back(exp_par);
    seq.push_back(1'b1);

    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait_timeout", 32'(waited < 200), 32'd1);
    check("idle_tx", 32'(tx_line), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_parity_hold", 32'(parity_bit), 32'(last_par));
    in_valid   = 1'b1;
    in_data    = d;
    in_odd     = odd;
    inject_err = inj;
    @(posedge clk);
    hs = cyc;
    if (chk_gap) check("hs_spacing", 32'(hs - last_hs), 32'(FrameLen + 1));
    last_hs = hs;

    for (int k = 1; k <= FrameLen; k++) begin
      @(negedge clk);
      check("tx_line", 32'(tx_line), 32'(seq[(k - 1) / Cpb]));
      check("busy", 32'(busy), 32'd1);
      check("in_ready", 32'(in_ready), 32'd0);
      check("frame_done", 32'(frame_done), 32'(k == FrameLen));
      check("parity_bit", 32'(parity_bit), 32'(exp_par));
      if (!keep_valid) in_valid = 1'b0;
      in_data    = DataW'($urandom);
      in_odd     = 1'($urandom);
      inject_err = 1'($urandom);
      if (k == abort_at) return;
    end
    last_par = exp_par;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    last_hs    = 0;
    last_par   = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_odd     = 1'b0;
    inject_err = 1'b0;

    #12;
    check("rst_tx", 32'(tx_line), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_parity", 32'(parity_bit), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Even and odd frames of 3'b101.
    run_frame(3'b101, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_frame(3'b101, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back with in_valid held high; second handshake FrameLen+1 cycles later.
    run_frame(3'b011, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_frame(3'b111, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    in_valid = 1'b0;

    // Mid-frame input changes (run_frame scrambles inputs every cycle) with valid held high.
    run_frame(3'b001, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    in_valid = 1'b0;

    // Injection: parity on the line is 1 only when the macro is defined.
    run_frame(3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Reset asserted in cycle 10 of a frame: outputs return to idle asynchronously.
    run_frame(3'b110, 1'b1, 1'b0, 1'b0, 10, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx_line), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_done", 32'(frame_done), 32'd0);
    check("midrst_parity", 32'(parity_bit), 32'd0);
    in_valid = 1'b0;
    last_par = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(3'b010, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Random frames, random back-to-back choice.
    for (int n = 0; n < 20; n++) begin
      bit kv;
      kv = 1'($urandom);
      run_frame(DataW'($urandom), 1'($urandom), 1'($urandom), kv, 0, 1'b0);
      if (!kv) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle_tx", 32'(tx_line), 32'd1);
    check("final_idle_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
